// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding and bit-timing helper.
// Defining UART_RX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

  // halfBit selects the mid-bit offset instead of the full bit period
  function automatic int unsigned calcBitTiming(input int unsigned clkHz,
                                                input int unsigned baud,
                                                input logic halfBit);
    int unsigned bitCyc;
    bitCyc = clkHz / baud;
    return halfBit ? bitCyc / 2 : bitCyc;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with occupancy count; full/empty decode from the count.
// A pop frees a slot for a write in the same cycle; a pop never takes an entry written that cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  input  logic                         rd_en_i,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             push, pop;

  assign pop  = rd_en_i && (count_q != '0);
  assign push = wr_en_i && ((count_q != CW'(DEPTH)) || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wrPtr_q] <= wr_data_i;
        wrPtr_q        <= wrPtr_q + PW'(1);
      end
      if (pop) rdPtr_q <= rdPtr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign rd_data_o = mem_q[rdPtr_q];
  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign count_o   = count_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling FSM and FWFT receive FIFO.
// Optional parity bit before stop when UART_RX_PARITY_EN is defined; otherwise parity_err is tied 0.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int          DATA_BITS  = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter int          PARITY_ODD = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                uart_rxd,
  input  logic                                rd_en,
  output logic [DATA_BITS-1:0]                rd_data,
  output logic                                empty,
  output logic                                full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
  output logic                                frame_err,
  output logic                                parity_err,
  output logic                                overrun
);

  localparam int unsigned BIT_CYC = calcBitTiming(CLK_HZ, BAUD, 1'b0);
  localparam int unsigned HALF    = calcBitTiming(CLK_HZ, BAUD, 1'b1);
  localparam int TW = $clog2(BIT_CYC + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] BitLast  = TW'(BIT_CYC - 1);
  localparam logic [TW-1:0] HalfLast = TW'(HALF - 1);
  localparam logic [BW-1:0] BitsLast = BW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q;
  rx_state_t            state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bitCnt_q, bitCnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frameErr_q, frameErr_d;
  logic                 overrun_q, overrun_d;
  logic                 stopSample, parityOk, goodFrame, fifoWrEn;
`ifdef UART_RX_PARITY_EN
  logic                 parBit_q, parBit_d;
  logic                 parityErr_q, parityErr_d;
`endif

  // Idle-high reset value keeps a reset release from looking like a start edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parBit_q    <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parBit_q    <= parBit_d;
      parityErr_q <= parityErr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TW'(1);
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
`ifdef UART_RX_PARITY_EN
    parBit_d = parBit_q;
`endif
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!sync2_q) begin
          state_d  = START;
          bitCnt_d = '0;
        end
      end
      START: begin
        if (timer_q == HalfLast) begin
          timer_d = '0;
          state_d = sync2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_q == BitLast) begin
          timer_d  = '0;
          shift_d  = {sync2_q, shift_q[DATA_BITS-1:1]};
          bitCnt_d = bitCnt_q + BW'(1);
          if (bitCnt_q == BitsLast) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (timer_q == BitLast) begin
          timer_d  = '0;
          parBit_d = sync2_q;
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (timer_q == BitLast) begin
          timer_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the stop-sample cycle frees the slot, so a full FIFO still accepts the frame
  always_comb begin
    stopSample = (state_q == STOP) && (timer_q == BitLast);
`ifdef UART_RX_PARITY_EN
    parityOk   = (parBit_q == ((^shift_q) ^ (PARITY_ODD != 0)));
`else
    parityOk   = 1'b1;
`endif
    goodFrame  = stopSample && sync2_q && parityOk;
    fifoWrEn   = goodFrame && (!full || rd_en);
    overrun_d  = goodFrame && full && !rd_en;
    frameErr_d = stopSample && !sync2_q;
`ifdef UART_RX_PARITY_EN
    parityErr_d = stopSample && sync2_q && !parityOk;
`endif
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (fifoWrEn),
    .wr_data_i (shift_q),
    .rd_en_i   (rd_en),
    .rd_data_o (rd_data),
    .empty_o   (empty),
    .full_o    (full),
    .count_o   (count)
  );

  assign frame_err = frameErr_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parityErr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed self-checking bench for uart_rx_param at 16 clk per bit (HALF = 8).
// Parity frames and parity tests follow UART_RX_PARITY_EN.
module tb_uart_rx_param;

  localparam int unsigned CLK_HZ     = 1000000;
  localparam int unsigned BAUD       = 62500;
  localparam int          BIT        = 16;
  localparam int          DATA_BITS  = 8;
  localparam int          FIFO_DEPTH = 4;
  localparam int          PARITY_ODD = 0;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       rxd = 1'b1;
  logic       rdEn = 1'b0;
  logic [7:0] rdData;
  logic       empty, full;
  logic [2:0] count;
  logic       frameErr, parityErr, overrun;

  int checks = 0;
  int errors = 0;
  int frameErrCnt = 0;
  int parityErrCnt = 0;
  int overrunCnt = 0;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk        (clk),
    .reset      (resetN),
    .uart_rxd   (rxd),
    .rd_en      (rdEn),
    .rd_data    (rdData),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .frame_err  (frameErr),
    .parity_err (parityErr),
    .overrun    (overrun)
  );

  // Each high cycle of a pulse adds one, so a stretched pulse shows up as an extra count
  always @(negedge clk) begin
    if (frameErr)  frameErrCnt++;
    if (parityErr) parityErrCnt++;
    if (overrun)   overrunCnt++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic parityFor(input logic [7:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  // popAtStop raises rd_en for the single cycle of the mid-stop sample edge
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input logic parBit, input logic popAtStop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = parBit;
    repeat (BIT) @(negedge clk);
`else
    if (parBit === 1'bx) $display("[TB] unknown parity argument");
`endif
    rxd = stopBit;
    repeat (10) @(negedge clk);
    rdEn = popAtStop;
    @(negedge clk);
    rdEn = 1'b0;
    repeat (BIT - 11) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic popOne();
    @(negedge clk);
    rdEn = 1'b1;
    @(negedge clk);
    rdEn = 1'b0;
  endtask

  task automatic idleBits(input int n);
    repeat (n * BIT) @(negedge clk);
  endtask

  initial begin
    logic [7:0] drainExp [4];
    drainExp[0] = 8'h22;
    drainExp[1] = 8'h33;
    drainExp[2] = 8'h44;
    drainExp[3] = 8'h66;

    repeat (3) @(negedge clk);
    checkOutput("reset_empty", empty, 1);
    checkOutput("reset_full", full, 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_rd_data", rdData, 8'h00);
    checkOutput("reset_frame_err", frameErr, 0);
    checkOutput("reset_parity_err", parityErr, 0);
    checkOutput("reset_overrun", overrun, 0);
    resetN = 1'b1;
    idleBits(1);

    applyStimulus(8'h3C, 1'b1, parityFor(8'h3C), 1'b0);
    checkOutput("single_empty", empty, 0);
    checkOutput("single_rd_data", rdData, 8'h3C);
    checkOutput("single_count", count, 1);
    checkOutput("single_no_frame_err", frameErrCnt, 0);
    checkOutput("single_no_overrun", overrunCnt, 0);
    popOne();
    checkOutput("single_pop_empty", empty, 1);
    checkOutput("single_pop_count", count, 0);

    applyStimulus(8'h3C, 1'b1, parityFor(8'h3C), 1'b0);
    applyStimulus(8'h24, 1'b1, parityFor(8'h24), 1'b0);
    checkOutput("b2b_count", count, 2);
    checkOutput("b2b_head0", rdData, 8'h3C);
    popOne();
    checkOutput("b2b_head1", rdData, 8'h24);
    checkOutput("b2b_count_after_pop", count, 1);
    popOne();
    checkOutput("b2b_empty", empty, 1);

    applyStimulus(8'hA5, 1'b0, parityFor(8'hA5), 1'b0);
    checkOutput("ferr_pulse", frameErrCnt, 1);
    checkOutput("ferr_count", count, 0);
    idleBits(2);
    checkOutput("ferr_single_pulse", frameErrCnt, 1);
    checkOutput("ferr_still_empty", empty, 1);

    @(negedge clk);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    idleBits(2);
    checkOutput("glitch_count", count, 0);
    checkOutput("glitch_no_frame_err", frameErrCnt, 1);
    checkOutput("glitch_no_parity_err", parityErrCnt, 0);

    applyStimulus(8'h5A, 1'b1, parityFor(8'h5A), 1'b1);
    checkOutput("rdwr_empty_count", count, 1);
    checkOutput("rdwr_empty_data", rdData, 8'h5A);
    popOne();
    checkOutput("rdwr_empty_drained", empty, 1);

    applyStimulus(8'h11, 1'b1, parityFor(8'h11), 1'b0);
    applyStimulus(8'h22, 1'b1, parityFor(8'h22), 1'b0);
    applyStimulus(8'h33, 1'b1, parityFor(8'h33), 1'b0);
    applyStimulus(8'h44, 1'b1, parityFor(8'h44), 1'b0);
    checkOutput("fill_full", full, 1);
    checkOutput("fill_count", count, 4);
    checkOutput("fill_no_overrun", overrunCnt, 0);
    applyStimulus(8'h55, 1'b1, parityFor(8'h55), 1'b0);
    checkOutput("ovr_pulse", overrunCnt, 1);
    checkOutput("ovr_count", count, 4);
    checkOutput("ovr_head", rdData, 8'h11);
    applyStimulus(8'h66, 1'b1, parityFor(8'h66), 1'b1);
    checkOutput("ovr_pop_no_pulse", overrunCnt, 1);
    checkOutput("ovr_pop_count", count, 4);
    checkOutput("ovr_pop_full", full, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_%0d", i), rdData, drainExp[i]);
      popOne();
    end
    checkOutput("drain_empty", empty, 1);

`ifdef UART_RX_PARITY_EN
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0);
    checkOutput("par_bad_pulse", parityErrCnt, 1);
    checkOutput("par_bad_dropped", count, 0);
    checkOutput("par_bad_no_frame_err", frameErrCnt, 1);
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b0);
    checkOutput("par_good_count", count, 1);
    checkOutput("par_good_data", rdData, 8'h07);
    checkOutput("par_good_no_pulse", parityErrCnt, 1);
    popOne();
`else
    checkOutput("nopar_err_tied", parityErrCnt, 0);
`endif

    applyStimulus(8'h3C, 1'b1, parityFor(8'h3C), 1'b0);
    checkOutput("rst_pre_count", count, 1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    rxd = 1'b1;
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mid_empty", empty, 1);
    checkOutput("rst_mid_count", count, 0);
    resetN = 1'b1;
    idleBits(2);
    checkOutput("rst_no_spurious", count, 0);
    applyStimulus(8'h5A, 1'b1, parityFor(8'h5A), 1'b0);
    checkOutput("rst_next_count", count, 1);
    checkOutput("rst_next_data", rdData, 8'h5A);
    checkOutput("rst_next_no_frame_err", frameErrCnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver with mid-bit sampling, configurable data width and an integrated receive FIFO. It converts the asynchronous `uart_rxd` line into bytes that the CPU-side peripheral logic pops with a first-word-fall-through read port. It replaces the fixed 8N1 receive path inside the top-level peripheral bus.

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- BAUD, 9600, line rate in bit/s
- DATA_BITS, 8, data bits per frame (5..9), LSB first
- FIFO_DEPTH, 4, receive FIFO entries (power of two, ≥2)
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only when parity is compiled in)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- uart_rxd  in  1  serial line, idle high, asynchronous to clk
- rd_en  in  1  pop head entry when !empty
- rd_data  out  DATA_BITS  FIFO head, valid while !empty
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- count  out  $clog2(FIFO_DEPTH+1)  entries held
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- parity_err  out  1  one-cycle pulse: parity mismatch
- overrun  out  1  one-cycle pulse: good frame dropped because FIFO full

## Operation
- `uart_rxd` passes through a 2-flop synchroniser, reset value 1; all decisions use the synchronised value.
- BIT_CYC = CLK_HZ/BAUD (truncated integer); HALF = BIT_CYC/2. Defaults give 5208 and 2604.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: synchronised line low -> START, clear the bit counter.
- START: after HALF cycles, sample; low -> DATA, high -> IDLE (false start, no error pulse).
- DATA: sample every BIT_CYC cycles and shift in LSB first; after DATA_BITS samples go to PARITY if compiled in, otherwise STOP.
- PARITY: sample once after BIT_CYC; compare with XOR of data (inverted when PARITY_ODD=1).
- STOP: sample after BIT_CYC. High with parity OK -> write to the FIFO, or pulse overrun if the FIFO is full and no pop occurs that cycle. Low -> pulse frame_err, discard the byte. Parity bad with stop high -> pulse parity_err, discard. Return to IDLE in the same cycle. The next start edge can be detected during the second half of the stop bit.
- FIFO write when full in the same cycle as rd_en: the pop happens first and the write is accepted, count unchanged, no overrun.
- rd_en while empty is ignored. rd_en with a write into an empty FIFO does not pop the new entry.
- Pointers wrap modulo FIFO_DEPTH. The full/empty decode comes from count.

## Timing
- Reset values: rd_data 0, empty 1, full 0, count 0, all error pulses 0, state IDLE, synchroniser 1.
- Reset asserted mid-frame aborts the frame and flushes the FIFO. After release, reception starts only on a new falling edge.
- Start-edge detection latency is 2 clk (synchroniser).
- A byte becomes visible (empty falls) 1 clk after the mid-stop sample, about 2 + HALF + (DATA_BITS+1[+1])·BIT_CYC clk after the line falls.
- Error pulses assert for exactly 1 clk, registered, in the cycle after the mid-stop sample.
- rd_data and count update 1 clk after an rd_en pop.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state is present, frames carry one parity bit before stop, and parity_err is driven.
- UART_RX_PARITY_EN undefined: the PARITY state is removed, frames are DATA_BITS-N-1, and parity_err is tied 0.

## Structure
- Shared package uart_pkg: state enum `rx_state_t`, and a function computing BIT_CYC/HALF from CLK_HZ/BAUD.
- One sub-module `uart_rx_fifo` (DATA_BITS wide, FIFO_DEPTH deep, FWFT, count output). The deserialiser FSM and bit-timing counter stay in the top module.

## Test plan
- Defaults, line low at t0, send 8N1 0x3C at 104 µs/bit -> empty falls about 9.5 bit times later, rd_data=0x3C, count=1, no error pulses.
- Back-to-back 0x3C then 0x24, no read -> count=2, pop order 0x3C, 0x24, then empty=1.
- Stop bit driven low on 0xA5 -> frame_err pulses 1 clk, count unchanged.
- Line low for 1000 clk then high (glitch shorter than HALF) -> stays IDLE, no write, no error.
- FIFO_DEPTH=4, send 5 frames without reading -> full=1 after 4, overrun pulse on the 5th. Repeat with rd_en coincident with the 5th write -> no overrun, count=4.
- UART_RX_PARITY_EN, PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err pulse, byte dropped. Same frame with parity bit 1 -> accepted. Also assert reset mid-frame -> empty=1, next frame received cleanly.
